fetch_unit: RTL

// - Instruction-fetch stage: owns the PC, fetches over a req/ack instruction-memory port, holds the

---
 rtl/mips_pkg.sv | 20 ++
 rtl/next_pc_calc.sv | 29 ++
 rtl/fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM encoding and default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump over taken branch over sequential; all targets word-aligned.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        pc_src,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // opcode field plays no part in target formation; the decoder already chose jump/pc_src
    wire unused_opcode = &{1'b0, instr[31:26]};

    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = jump_target;
        else if (pc_src)
            next_pc = branch_target;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack imem fetch FSM with timeout, held instruction.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        pc_src,
    input  logic        jump,
    output logic        fetch_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    fetch_state_t  state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];

    next_pc_calc u_next_pc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .jump     (jump),
        .pc_src   (pc_src),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    // a late ack in the timeout cycle still wins
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        wait_cnt    <= '0;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end else if (wait_cnt == LAST_WAIT) begin
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        state     <= ERR;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                EXEC: begin
                    if (retire) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
                default: state <= ERR;
            endcase
        end
    end

endmodule
